// File: rtl/histogram_engine.sv
// Event histogram: counts events into 2^BIN_AW bins, streams them out as NB beats on dump_req or bin overflow.
// Latency: event visible in bin next cycle; dump beats start the cycle after DUMP entry, one per accepted beat; in_ready=0 while busy.
module histogram_engine #(
  parameter int BIN_AW        = 6,
  parameter int CNT_W         = 4,
  parameter int CLEAR_ON_DUMP = 1
) (
  input  logic              clk,
  input  logic              bin_reset,
  input  logic              in_valid,
  input  logic [BIN_AW-1:0] in_bin,
  output logic              in_ready,
  input  logic              sat_mode,
  input  logic              dump_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_data,
  output logic [BIN_AW-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              ovf
);

  localparam int NB = 1 << BIN_AW;
  localparam logic [CNT_W-1:0]  MAX      = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  MAX_M1   = MAX - CNT_ONE;
  localparam logic [BIN_AW-1:0] LAST_IDX = '1;
  localparam logic [BIN_AW-1:0] IDX_ONE  = {{(BIN_AW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ACCUM, DUMP, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  bins_q [NB];
  logic [CNT_W-1:0]  bins_d [NB];
  logic [BIN_AW-1:0] k_q, k_d;
  logic              ovf_q, ovf_d;

  logic              accept;
  logic              beat_fire;
  logic              is_last;
  logic [CNT_W-1:0]  cur_cnt;

  assign in_ready  = (state_q == ACCUM);
  assign busy      = ~in_ready;
  assign out_valid = (state_q == DUMP);
  assign is_last   = (k_q == LAST_IDX);
  assign accept    = in_valid && in_ready;
  assign beat_fire = out_valid && out_ready;
  assign cur_cnt   = bins_q[in_bin];
  assign out_index = k_q;
  assign out_last  = out_valid && is_last;
  assign out_data  = out_valid ? bins_q[k_q] : '0;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    ovf_d   = ovf_q;
    bins_d  = bins_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          if (cur_cnt == MAX) begin
            ovf_d = 1'b1;
          end else begin
            bins_d[in_bin] = cur_cnt + CNT_ONE;
            // sat_mode is taken from the accepting cycle only
            if (!sat_mode && (cur_cnt == MAX_M1)) state_d = DUMP;
          end
        end
        if (dump_req) state_d = DUMP;
        if (state_d == DUMP) begin
          k_d = '0;
          if (CLEAR_ON_DUMP == 0) ovf_d = 1'b0;
        end
      end
      DUMP: begin
        if (beat_fire) begin
          k_d = k_q + IDX_ONE;
          if (is_last) begin
            k_d     = '0;
            state_d = (CLEAR_ON_DUMP != 0) ? CLEAR : ACCUM;
          end
        end
      end
      CLEAR: begin
        for (int i = 0; i < NB; i++) bins_d[i] = '0;
        ovf_d   = 1'b0;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge bin_reset) begin
    if (bin_reset) begin
      state_q <= ACCUM;
      k_q     <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < NB; i++) bins_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NB; i++) bins_q[i] <= bins_d[i];
    end
  end

endmodule

// File: tb/tb_histogram_engine.sv
// Directed bench for histogram_engine: a bin model fills a beat queue at each dump,
// and the DUT's beats are popped and compared as they are accepted.
module tb_histogram_engine;

  logic       clk;
  logic       bin_reset;
  // instance 0: CLEAR_ON_DUMP=1
  logic       in_valid, in_ready, sat_mode, dump_req, out_valid, out_ready, out_last, busy, ovf;
  logic [5:0] in_bin, out_index;
  logic [3:0] out_data;
  // instance 1: CLEAR_ON_DUMP=0
  logic       in_valid1, in_ready1, sat_mode1, dump_req1, out_valid1, out_ready1, out_last1, busy1, ovf1;
  logic [5:0] in_bin1, out_index1;
  logic [3:0] out_data1;

  typedef struct {int idx; int data; bit last;} beat_t;
  beat_t exp_q[$];
  int    exp0 [64];
  int    exp1 [64];
  int    n_pass  = 0;
  int    n_total = 0;
  int    cyc;

  histogram_engine #(.BIN_AW(6), .CNT_W(4), .CLEAR_ON_DUMP(1)) dut (
    .clk(clk), .bin_reset(bin_reset), .in_valid(in_valid), .in_bin(in_bin), .in_ready(in_ready),
    .sat_mode(sat_mode), .dump_req(dump_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy), .ovf(ovf)
  );

  histogram_engine #(.BIN_AW(6), .CNT_W(4), .CLEAR_ON_DUMP(0)) dut1 (
    .clk(clk), .bin_reset(bin_reset), .in_valid(in_valid1), .in_bin(in_bin1), .in_ready(in_ready1),
    .sat_mode(sat_mode1), .dump_req(dump_req1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_index(out_index1), .out_last(out_last1), .busy(busy1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  task automatic send_event(input int bin, input bit d);
    if (d) begin
      chk("in_ready1_before_event", 32'(in_ready1), 32'd1);
      in_valid1 = 1'b1;
      in_bin1   = 6'(bin);
      if (exp1[bin] != 15) exp1[bin]++;
    end else begin
      chk("in_ready_before_event", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_bin   = 6'(bin);
      if (exp0[bin] != 15) exp0[bin]++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic pulse_dump(input bit d);
    if (d) dump_req1 = 1'b1; else dump_req = 1'b1;
    @(negedge clk);
    dump_req  = 1'b0;
    dump_req1 = 1'b0;
  endtask

  task automatic push_dump(input bit d);
    beat_t b;
    for (int i = 0; i < 64; i++) begin
      b.idx  = i;
      b.data = d ? exp1[i] : exp0[i];
      b.last = (i == 63);
      exp_q.push_back(b);
    end
  endtask

  // mode 0: out_ready always 1; mode 1: out_ready repeats 1,0,0,1
  task automatic drain(input int mode, input bit d, output int cycles);
    logic [3:0]  pat;
    logic [31:0] obs, ev;
    bit          rdy;
    beat_t       e;
    int          i;
    pat    = 4'b1001;
    cycles = 0;
    i      = 0;
    while (exp_q.size() > 0 && i < 2000) begin
      if (!(d ? out_valid1 : out_valid)) begin
        chk("out_valid_during_dump", 32'(d ? out_valid1 : out_valid), 32'd1);
        break;
      end
      e   = exp_q[0];
      obs = d ? 32'({out_index1, out_data1, out_last1}) : 32'({out_index, out_data, out_last});
      ev  = 32'((e.idx << 5) | (e.data << 1) | int'(e.last));
      chk("beat", obs, ev);
      rdy = (mode == 0) ? 1'b1 : pat[3 - (i % 4)];
      if (d) out_ready1 = rdy; else out_ready = rdy;
      if (rdy) void'(exp_q.pop_front());
      cycles++;
      i++;
      @(negedge clk);
      dump_req  = 1'b0;
      dump_req1 = 1'b0;
    end
    if (exp_q.size() > 0) chk("dump_beats_remaining", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bin_reset = 1'b1;
    in_valid = 1'b0; in_bin = '0; sat_mode = 1'b0; dump_req = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_bin1 = '0; sat_mode1 = 1'b0; dump_req1 = 1'b0; out_ready1 = 1'b1;
    foreach (exp0[i]) exp0[i] = 0;
    foreach (exp1[i]) exp1[i] = 0;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_beat", 32'({out_index, out_data, out_last}), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_in_ready1", 32'(in_ready1), 32'd1);
    @(negedge clk);
    bin_reset = 1'b0;
    @(negedge clk);

    // auto-dump when bin 5 reaches 15
    for (int n = 0; n < 15; n++) send_event(5, 1'b0);
    chk("autodump_in_ready", 32'(in_ready), 32'd0);
    chk("autodump_busy", 32'(busy), 32'd1);
    push_dump(1'b0);
    foreach (exp0[i]) exp0[i] = 0;
    drain(0, 1'b0, cyc);
    chk("dump_cycles", 32'(cyc), 32'd64);
    chk("clear_busy", 32'(busy), 32'd1);
    chk("clear_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("after_clear_in_ready", 32'(in_ready), 32'd1);

    // saturating mode: no auto-dump, ovf sticky until CLEAR
    sat_mode = 1'b1;
    for (int n = 0; n < 20; n++) send_event(2, 1'b0);
    chk("sat_no_autodump", 32'(in_ready), 32'd1);
    chk("sat_ovf_set", 32'(ovf), 32'd1);
    pulse_dump(1'b0);
    push_dump(1'b0);
    foreach (exp0[i]) exp0[i] = 0;
    drain(0, 1'b0, cyc);
    @(negedge clk);
    chk("sat_ovf_cleared", 32'(ovf), 32'd0);
    sat_mode = 1'b0;

    // event coincident with dump_req; dump_req held into DUMP; stalled output
    in_valid = 1'b1;
    in_bin   = 6'd7;
    dump_req = 1'b1;
    exp0[7]++;
    @(negedge clk);
    in_valid = 1'b0;
    push_dump(1'b0);
    foreach (exp0[i]) exp0[i] = 0;
    drain(1, 1'b0, cyc);
    chk("stall_dump_cycles", 32'(cyc), 32'd128);
    out_ready = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      chk("no_second_dump", 32'({out_valid, in_ready}), 32'b01);
      @(negedge clk);
    end

    // retained bins without CLEAR
    for (int n = 0; n < 3; n++) send_event(1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      pulse_dump(1'b1);
      push_dump(1'b1);
      drain(0, 1'b1, cyc);
      chk("retain_back_to_accum", 32'(in_ready1), 32'd1);
    end

    // reset in the middle of a dump
    send_event(3, 1'b0);
    pulse_dump(1'b0);
    for (int n = 0; n < 10; n++) @(negedge clk);
    chk("pre_reset_index", 32'(out_index), 32'd10);
    bin_reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_beat", 32'({out_index, out_data, out_last}), 32'd0);
    foreach (exp0[i]) exp0[i] = 0;
    foreach (exp1[i]) exp1[i] = 0;
    @(negedge clk);
    bin_reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      chk("no_beats_after_reset", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    pulse_dump(1'b0);
    push_dump(1'b0);
    drain(0, 1'b0, cyc);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
